// File: rtl/lfsr_rng_if.sv
// Draw/seed/observe bundle between the 1A2B digit generator and its LFSR random source.
// Latency: none (wires only).
// Backpressure: none; the requester waits for rnd_valid before issuing the next req.
interface lfsr_rng_if #(
    parameter int WIDTH = 14,
    parameter int OUT_W = 4
);
    logic             seed_load;
    logic [WIDTH-1:0] seed;
    logic             en;
    logic             req;
    logic             busy;
    logic             rnd_valid;
    logic [OUT_W-1:0] rnd;
    logic [WIDTH-1:0] ran;
    logic             period_wrap;

    // Requester side: loads seeds, enables free-run, asks for draws.
    modport master (
        output seed_load, seed, en, req,
        input  busy, rnd_valid, rnd, ran, period_wrap
    );

    // Generator side.
    modport slave (
        input  seed_load, seed, en, req,
        output busy, rnd_valid, rnd, ran, period_wrap
    );
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with bounded rejection-sampled draws in 0..LIMIT-1.
// Latency: req to rnd_valid is 2 edges plus 1 per rejection, at most MAX_REJ+2 edges.
// Backpressure: none; req is only sampled in IDLE, busy marks an in-flight draw.
module lfsr_rng #(
    parameter int               WIDTH    = 14,
    parameter logic [WIDTH-1:0] TAPS     = WIDTH'(14'h002B),
    parameter logic [WIDTH-1:0] RST_SEED = WIDTH'(1),
    parameter int               OUT_W    = 4,
    parameter int               LIMIT    = 10,
    parameter int               MAX_REJ  = 7
) (
    input  logic     clk,
    input  logic     rst,
    lfsr_rng_if.slave bus
);

    // A zero seed would lock the LFSR at zero forever, so it is replaced by 1.
    localparam logic [WIDTH-1:0] RST_LD  = (RST_SEED == '0) ? WIDTH'(1) : RST_SEED;
    localparam int               REJ_W   = (MAX_REJ > 0) ? $clog2(MAX_REJ + 1) : 1;
    localparam logic [REJ_W-1:0] REJ_MAX = REJ_W'(MAX_REJ);
    // One extra bit so LIMIT == 2^OUT_W is representable in the compare.
    localparam logic [OUT_W:0]   LIMIT_V = (OUT_W + 1)'(LIMIT);
    localparam logic [OUT_W-1:0] LIMIT_L = LIMIT_V[OUT_W-1:0];

    typedef enum logic {IDLE = 1'b0, DRAW = 1'b1} fsm_t;

    fsm_t             fsm;
    logic [WIDTH-1:0] state;
    logic [WIDTH-1:0] seed_reg;
    logic [REJ_W-1:0] rej_cnt;
    logic [OUT_W-1:0] rnd_r;
    logic             rnd_valid_r;
    logic             period_wrap_r;
    logic             busy_r;

    logic             fb;
    logic [WIDTH-1:0] nxt;
    logic [WIDTH-1:0] ld;
    logic [OUT_W-1:0] cand;
    logic             cand_ok;

    // Next-state of the shift register, the sanitised seed and the current draw candidate.
    always_comb begin
        fb      = ^(state & TAPS);
        nxt     = {fb, state[WIDTH-1:1]};
        ld      = (bus.seed == '0) ? WIDTH'(1) : bus.seed;
        cand    = state[OUT_W-1:0];
        cand_ok = ({1'b0, cand} < LIMIT_V);
    end

    // Seed loading, free-run stepping and the IDLE/DRAW rejection-sampling controller.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= RST_LD;
            seed_reg      <= RST_LD;
            fsm           <= IDLE;
            rej_cnt       <= '0;
            rnd_r         <= '0;
            rnd_valid_r   <= 1'b0;
            period_wrap_r <= 1'b0;
            busy_r        <= 1'b0;
        end else begin
            // Pulses default low; only a result or a wrapping step raises them.
            rnd_valid_r   <= 1'b0;
            period_wrap_r <= 1'b0;
            if (bus.seed_load) begin
                // Aborts any draw in flight without producing a result for it.
                state    <= ld;
                seed_reg <= ld;
                fsm      <= IDLE;
                busy_r   <= 1'b0;
                rej_cnt  <= '0;
            end else begin
                case (fsm)
                    IDLE: begin
                        if (bus.req) begin
                            state         <= nxt;
                            period_wrap_r <= (nxt == seed_reg);
                            rej_cnt       <= '0;
                            fsm           <= DRAW;
                            busy_r        <= 1'b1;
                        end else if (bus.en) begin
                            state         <= nxt;
                            period_wrap_r <= (nxt == seed_reg);
                        end
                    end
                    DRAW: begin
                        if (cand_ok) begin
                            rnd_r       <= cand;
                            rnd_valid_r <= 1'b1;
                            fsm         <= IDLE;
                            busy_r      <= 1'b0;
                        end else if (rej_cnt == REJ_MAX) begin
                            // cand >= LIMIT and LIMIT > 2^(OUT_W-1), so the difference is < LIMIT.
                            rnd_r       <= cand - LIMIT_L;
                            rnd_valid_r <= 1'b1;
                            fsm         <= IDLE;
                            busy_r      <= 1'b0;
                        end else begin
                            rej_cnt       <= rej_cnt + REJ_W'(1);
                            state         <= nxt;
                            period_wrap_r <= (nxt == seed_reg);
                        end
                    end
                    default: begin
                        fsm    <= IDLE;
                        busy_r <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy        = busy_r;
    assign bus.rnd_valid   = rnd_valid_r;
    assign bus.rnd         = rnd_r;
    assign bus.ran         = state;
    assign bus.period_wrap = period_wrap_r;

endmodule
